// File: rtl/gpr_writeback.sv
// gpr_writeback: merges single-cycle ALU results and buffered LSU load
// results onto the single GPR write port, and tracks outstanding loads in
// a per-register busy mask.
// Optional feature macro: WB_BYPASS_EN -- an LSU beat arriving into an empty
// FIFO during an ALU-idle cycle skips the FIFO and is written with latency 1.
module gpr_writeback #(
  parameter int GPR_BITS       = 64,
  parameter int GPR_ID_BITS    = 5,
  parameter int LSU_FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  input  logic [GPR_ID_BITS-1:0]      alu_id,
  input  logic [GPR_BITS-1:0]         alu_val,
  input  logic                        lsu_valid,
  output logic                        lsu_ready,
  input  logic [GPR_ID_BITS-1:0]      lsu_id,
  input  logic [GPR_BITS-1:0]         lsu_val,
  input  logic                        issue_valid,
  input  logic [GPR_ID_BITS-1:0]      issue_id,
  output logic [(1<<GPR_ID_BITS)-1:0] busy_mask,
  output logic                        we,
  output logic [GPR_ID_BITS-1:0]      write_id,
  output logic [GPR_BITS-1:0]         write_val
);

  localparam int NREG = 1 << GPR_ID_BITS;
  localparam int AW   = $clog2(LSU_FIFO_DEPTH);
  localparam logic [AW:0]   CNT_FULL = LSU_FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  // Load-result FIFO storage and control
  logic [GPR_ID_BITS-1:0] fifo_id  [LSU_FIFO_DEPTH];
  logic [GPR_BITS-1:0]    fifo_val [LSU_FIFO_DEPTH];
  logic [AW-1:0]          rd_ptr, wr_ptr;
  logic [AW:0]            count;

  // Arbitration results for the write stage
  logic                   lsu_push, byp, fifo_push, fifo_pop;
  logic                   win_vld_p0, win_lsu_p0;
  logic [GPR_ID_BITS-1:0] win_id_p0;
  logic [GPR_BITS-1:0]    win_val_p0;
  logic [NREG-1:0]        busy_nxt;

  // Ready depends only on FIFO occupancy, never on lsu_valid.
  assign lsu_ready = (count != CNT_FULL);

  // Accept/bypass decision, fixed-priority write arbitration, busy-mask next state
  always_comb begin
    lsu_push = lsu_valid && lsu_ready;
    byp      = 1'b0;
`ifdef WB_BYPASS_EN
    byp      = lsu_push && (count == '0) && !alu_valid;
`else
    byp      = 1'b0;
`endif
    fifo_push = lsu_push && !byp;
    fifo_pop  = !alu_valid && (count != '0);

    win_vld_p0 = 1'b0;
    win_lsu_p0 = 1'b0;
    win_id_p0  = '0;
    win_val_p0 = '0;
    if (alu_valid) begin
      win_vld_p0 = 1'b1;
      win_id_p0  = alu_id;
      win_val_p0 = alu_val;
    end else if (fifo_pop) begin
      win_vld_p0 = 1'b1;
      win_lsu_p0 = 1'b1;
      win_id_p0  = fifo_id[rd_ptr];
      win_val_p0 = fifo_val[rd_ptr];
    end else if (byp) begin
      win_vld_p0 = 1'b1;
      win_lsu_p0 = 1'b1;
      win_id_p0  = lsu_id;
      win_val_p0 = lsu_val;
    end

    // Clear first so that a same-cycle set on the same bit wins.
    busy_nxt = busy_mask;
    if (win_vld_p0 && win_lsu_p0)
      busy_nxt[win_id_p0] = 1'b0;
    if (issue_valid && (issue_id != '0))
      busy_nxt[issue_id] = 1'b1;
  end

  // FIFO entry storage; stale contents are harmless once pointers reset
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_id[wr_ptr]  <= lsu_id;
      fifo_val[wr_ptr] <= lsu_val;
    end
  end

  // FIFO pointers/count and busy mask
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      busy_mask <= '0;
    end else begin
      if (fifo_push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (fifo_pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({fifo_push, fifo_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      busy_mask <= busy_nxt;
    end
  end

  // ---- stage p0 -> registered GPR write port ----
  // Register the winning write; id 0 is consumed but never enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      we        <= 1'b0;
      write_id  <= '0;
      write_val <= '0;
    end else begin
      we <= win_vld_p0 && (win_id_p0 != '0);
      if (win_vld_p0) begin
        write_id  <= win_id_p0;
        write_val <= win_val_p0;
      end
    end
  end

endmodule
